// File: rtl/stream_demux_nway_pkg.sv
// Shared constants for the buffered 1-to-N stream demultiplexer:
// per-port FIFO depth/count width and default geometry.
package stream_demux_nway_pkg;
   localparam int FIFO_DEPTH  = 2;
   localparam int CNT_W       = 2;
   localparam int DEF_WIDTH   = 32;
   localparam int DEF_NUM_OUT = 8;
   localparam int DEF_SEL_W   = 3;
endpackage

// File: rtl/stream_demux_nway_fifo2.sv
// demux_fifo2: 2-entry head/tail FIFO. The head register keeps the last
// popped value when the FIFO drains, so dout never goes stale-to-zero.
module demux_fifo2
   import stream_demux_nway_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] head, tail;
   logic             do_push, do_pop;

   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & (count != '0);
   assign dout    = head;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else begin
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         if (do_pop) begin
            // full FIFO shifts tail into head; at one entry a same-cycle push becomes the head
            if (count == CNT_W'(FIFO_DEPTH)) head <= tail;
            else if (do_push)                head <= din;
         end else if (do_push) begin
            if (count == '0) head <= din;
            else             tail <= din;
         end
      end
   end
endmodule

// File: rtl/stream_demux_nway.sv
// stream_demux_nway: 1-to-N valid/ready demux with a 2-entry FIFO per port.
// Optional broadcast input in_bcast when STREAM_DEMUX_BCAST_EN is defined.
module stream_demux_nway
   import stream_demux_nway_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_OUT = DEF_NUM_OUT,
   parameter int SEL_W   = DEF_SEL_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [SEL_W-1:0]         in_sel,
`ifdef STREAM_DEMUX_BCAST_EN
   input  logic                     in_bcast,
`endif
   output logic [NUM_OUT-1:0]       out_valid,
   input  logic [NUM_OUT-1:0]       out_ready,
   output logic [NUM_OUT*WIDTH-1:0] out_data,
   output logic                     drop_err
);
   localparam int SEL_N = 1 << SEL_W;

   logic [NUM_OUT-1:0]            full, push;
   logic [NUM_OUT-1:0][CNT_W-1:0] cnt;
   logic [SEL_N-1:0]              full_pad;
   logic                          sel_oor, bcast, fire;

`ifdef STREAM_DEMUX_BCAST_EN
   assign bcast = in_bcast;
`else
   assign bcast = 1'b0;
`endif

   // pad so any in_sel value indexes safely; unused selects read as not-full
   always_comb begin
      full_pad               = '0;
      full_pad[NUM_OUT-1:0]  = full;
   end

   assign sel_oor  = (32'(in_sel) >= NUM_OUT);
   assign in_ready = rst_n & (bcast ? ~|full : (sel_oor | ~full_pad[in_sel]));
   assign fire     = in_valid & in_ready;

   for (genvar i = 0; i < NUM_OUT; i++) begin : g_port
      assign push[i]      = fire & (bcast | (32'(in_sel) == i));
      assign out_valid[i] = (cnt[i] != '0);

      demux_fifo2 #(.WIDTH(WIDTH)) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[i]),
         .pop   (out_ready[i]),
         .din   (in_data),
         .dout  (out_data[i*WIDTH +: WIDTH]),
         .full  (full[i]),
         .count (cnt[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                        drop_err <= 1'b0;
      else if (fire & ~bcast & sel_oor)  drop_err <= 1'b1;
   end
endmodule

// File: tb/tb_stream_demux_nway.sv
// Directed bench for stream_demux_nway: an 8-port instance for routing,
// backpressure and ordering, and a 6-port instance for out-of-range drops.
module tb_stream_demux_nway;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic [W-1:0]   in_data = '0;
   logic [2:0]     in_sel = '0;
   logic [7:0]     out_ready = '0;
`ifdef STREAM_DEMUX_BCAST_EN
   logic           in_bcast = 1'b0;
`endif

   logic           in_ready_a, drop_err_a;
   logic [7:0]     out_valid_a;
   logic [8*W-1:0] out_data_a;
   logic           in_ready_b, drop_err_b;
   logic [5:0]     out_valid_b;
   logic [6*W-1:0] out_data_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stream_demux_nway #(.WIDTH(W), .NUM_OUT(8), .SEL_W(3)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .in_sel(in_sel),
`ifdef STREAM_DEMUX_BCAST_EN
      .in_bcast(in_bcast),
`endif
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
      .drop_err(drop_err_a)
   );

   stream_demux_nway #(.WIDTH(W), .NUM_OUT(6), .SEL_W(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .in_sel(in_sel),
`ifdef STREAM_DEMUX_BCAST_EN
      .in_bcast(in_bcast),
`endif
      .out_valid(out_valid_b), .out_ready(out_ready[5:0]), .out_data(out_data_b),
      .drop_err(drop_err_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pa(input int p);
      return out_data_a[p*W +: W];
   endfunction

   initial begin
      // reset
      step(); step();
      chk("rst_valid_a", out_valid_a, 8'h00);
      chk("rst_valid_b", out_valid_b, 6'h00);
      chk("rst_drop", drop_err_a, 1'b0);
      chk("rst_ready", in_ready_a, 1'b0);
      chk("rst_data", out_data_a[63:0], 64'h0);
      rst_n = 1'b1;
      #1 chk("post_rst_ready", in_ready_a, 1'b1);

      // single beat to port 5, then pop; data holds after drain
      in_valid = 1'b1; in_sel = 3'd5; in_data = 32'hDEADBEEF;
      #1 chk("t1_ready", in_ready_a, 1'b1);
      step(); in_valid = 1'b0;
      chk("t1_valid", out_valid_a, 8'h20);
      chk("t1_data", pa(5), 32'hDEADBEEF);
      out_ready = 8'h20;
      step(); out_ready = 8'h00;
      chk("t1_pop_valid", out_valid_a, 8'h00);
      chk("t1_hold_data", pa(5), 32'hDEADBEEF);

      // fill port 2; third beat stalls
      in_valid = 1'b1; in_sel = 3'd2; in_data = 32'hA;
      #1 chk("t2_rdy_a", in_ready_a, 1'b1);
      step(); in_data = 32'hB;
      #1 chk("t2_rdy_b", in_ready_a, 1'b1);
      step(); in_data = 32'hC;
      #1 chk("t2_rdy_c", in_ready_a, 1'b0);
      step();
      chk("t2_stall", in_ready_a, 1'b0);
      chk("t2_valid", out_valid_a, 8'h04);
      chk("t2_head", pa(2), 32'hA);

      // port 2 full does not block port 3
      in_sel = 3'd3; in_data = 32'h33;
      #1 chk("t3_rdy", in_ready_a, 1'b1);
      step();
      chk("t3_valid", out_valid_a, 8'h0C);
      chk("t3_data", pa(3), 32'h33);

      // drain port 2 while retrying C; ready only rises after the pop
      in_sel = 3'd2; in_data = 32'hC; out_ready = 8'h0C;
      #1 chk("t2_rdy_nocomb", in_ready_a, 1'b0);
      step();
      chk("t2_ord_b", pa(2), 32'hB);
      chk("t2_valid_b", out_valid_a, 8'h04);
      chk("t2_rdy_rise", in_ready_a, 1'b1);
      step(); in_valid = 1'b0;
      chk("t2_ord_c", pa(2), 32'hC);
      chk("t2_valid_c", out_valid_a, 8'h04);
      step(); out_ready = 8'h00;
      chk("t2_drained", out_valid_a, 8'h00);

      // push+pop at cnt=1 on port 0
      in_valid = 1'b1; in_sel = 3'd0; in_data = 32'h100;
      step(); in_valid = 1'b0;
      chk("t4_valid", out_valid_a, 8'h01);
      chk("t4_head0", pa(0), 32'h100);
      out_ready = 8'h01; in_valid = 1'b1; in_data = 32'h200;
      #1 chk("t4_rdy", in_ready_a, 1'b1);
      step(); in_valid = 1'b0; out_ready = 8'h00;
      chk("t4_valid_pp", out_valid_a, 8'h01);
      chk("t4_head1", pa(0), 32'h200);
      out_ready = 8'h01;
      step(); out_ready = 8'h00;
      chk("t4_drained", out_valid_a, 8'h00);

`ifdef STREAM_DEMUX_BCAST_EN
      in_valid = 1'b1; in_bcast = 1'b1; in_data = 32'hA5A5A5A5;
      step();
      chk("bc_valid", out_valid_a, 8'hFF);
      chk("bc_data7", pa(7), 32'hA5A5A5A5);
      chk("bc_valid_b", out_valid_b, 6'h3F);
      in_data = 32'h5A5A5A5A;
      step();
      chk("bc_full_rdy", in_ready_a, 1'b0);
      in_valid = 1'b0; in_bcast = 1'b0;
      chk("bc_drop", drop_err_a, 1'b0);
      out_ready = 8'hFF;
      step(); step(); out_ready = 8'h00;
      chk("bc_drained", out_valid_a, 8'h00);
`endif

      // reset mid-transfer discards buffered beats
      in_valid = 1'b1; in_sel = 3'd1; in_data = 32'h77;
      step(); in_valid = 1'b0;
      chk("mr_valid", out_valid_a, 8'h02);
      rst_n = 1'b0;
      step();
      chk("mr_cleared", out_valid_a, 8'h00);
      chk("mr_ready", in_ready_a, 1'b0);
      rst_n = 1'b1;

      // out-of-range select on the 6-port instance
      chk("t5_drop_pre", drop_err_b, 1'b0);
      in_valid = 1'b1; in_sel = 3'd7; in_data = 32'h1234;
      #1 chk("t5_rdy", in_ready_b, 1'b1);
      step(); in_valid = 1'b0;
      chk("t5_valid", out_valid_b, 6'h00);
      chk("t5_drop", drop_err_b, 1'b1);
      chk("t5_a_port7", out_valid_a, 8'h80);
      step(); step();
      chk("t5_sticky", drop_err_b, 1'b1);
      rst_n = 1'b0;
      step();
      chk("t5_drop_rst", drop_err_b, 1'b0);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
